// File: rtl/serial_seg_shifter.sv
// Serial shift-out engine for daisy-chained seven-segment / LED shift registers.
// Optional feature macro: SEG_AUTO_REFRESH_EN (periodic re-send of the last frame while idle).
module serial_seg_shifter #(
    parameter int DATA_WIDTH     = 64,
    parameter int DIV            = 2,
    parameter int REFRESH_PERIOD = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  load,
    output logic                  busy,
    output logic                  done,
    output logic                  sclk,
    output logic                  sdo,
    output logic                  pen,
    output logic                  clr_n
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int DW = (2 * DIV > 1) ? $clog2(2 * DIV) : 1;

    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(2 * DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(DIV);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic [DATA_WIDTH-1:0] sr_r;
    logic [DATA_WIDTH-1:0] sr_s;
    logic [BW-1:0]         bit_cnt_r;
    logic [BW-1:0]         bit_cnt_s;
    logic [DW-1:0]         div_cnt_r;
    logic [DW-1:0]         div_cnt_s;
    logic [DATA_WIDTH-1:0] pend_data_r;
    logic [DATA_WIDTH-1:0] pend_data_s;
    logic                  pend_valid_r;
    logic                  pend_valid_s;

    logic                  start_s;
    logic [DATA_WIDTH-1:0] start_data_s;
    logic                  load_taken_s;
    logic                  done_s;
    logic                  refresh_fire_s;
    logic [DATA_WIDTH-1:0] shadow_data_s;

    logic                  sclk_s;
    logic                  sdo_s;
    logic                  pen_s;
    logic                  busy_s;

    logic                  sclk_r;
    logic                  sdo_r;
    logic                  pen_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  clr_n_r;

`ifdef SEG_AUTO_REFRESH_EN
    localparam int RW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    localparam logic [RW-1:0] RP_LAST = RW'(REFRESH_PERIOD - 1);

    logic [RW-1:0]         idle_cnt_r;
    logic [DATA_WIDTH-1:0] shadow_r;
    logic                  shadow_valid_r;

    assign refresh_fire_s = (state_r == ST_IDLE) && !pend_valid_r && !load &&
                            shadow_valid_r && (idle_cnt_r == RP_LAST);
    assign shadow_data_s  = shadow_r;

    // Idle counter and shadow copy of the most recently started frame
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_r     <= '0;
            shadow_r       <= '0;
            shadow_valid_r <= 1'b0;
        end else begin
            if (start_s) begin
                shadow_r       <= start_data_s;
                shadow_valid_r <= 1'b1;
            end else begin
                shadow_r       <= shadow_r;
                shadow_valid_r <= shadow_valid_r;
            end
            // Saturate so an idle block with nothing to resend never wraps
            if ((state_r == ST_IDLE) && (state_s == ST_IDLE) && !pend_valid_r) begin
                if (idle_cnt_r != RP_LAST) begin
                    idle_cnt_r <= idle_cnt_r + RW'(1);
                end else begin
                    idle_cnt_r <= idle_cnt_r;
                end
            end else begin
                idle_cnt_r <= '0;
            end
        end
    end
`else
    assign refresh_fire_s = 1'b0;
    assign shadow_data_s  = '0;
`endif

    // Next-state, datapath and pending-buffer decisions
    always_comb begin
        state_s      = state_r;
        sr_s         = sr_r;
        bit_cnt_s    = bit_cnt_r;
        div_cnt_s    = div_cnt_r;
        pend_data_s  = pend_data_r;
        pend_valid_s = pend_valid_r;
        start_s      = 1'b0;
        start_data_s = '0;
        load_taken_s = 1'b0;
        done_s       = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (load) begin
                    start_s      = 1'b1;
                    start_data_s = data_in;
                    load_taken_s = 1'b1;
                end else if (refresh_fire_s) begin
                    start_s      = 1'b1;
                    start_data_s = shadow_data_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (div_cnt_r == DIV_LAST) begin
                    div_cnt_s = '0;
                    sr_s      = {sr_r[DATA_WIDTH-2:0], 1'b0};
                    if (bit_cnt_r == LAST_BIT) begin
                        bit_cnt_s = '0;
                        state_s   = ST_LATCH;
                    end else begin
                        bit_cnt_s = bit_cnt_r + BW'(1);
                    end
                end else begin
                    div_cnt_s = div_cnt_r + DW'(1);
                end
            end
            ST_LATCH: begin
                if (div_cnt_r == DIV_LAST) begin
                    div_cnt_s = '0;
                    done_s    = 1'b1;
                    if (pend_valid_r) begin
                        start_s      = 1'b1;
                        start_data_s = pend_data_r;
                        pend_valid_s = 1'b0;
                    end else if (load) begin
                        // Nothing queued: a load arriving on the exit cycle starts directly
                        start_s      = 1'b1;
                        start_data_s = data_in;
                        load_taken_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    div_cnt_s = div_cnt_r + DW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        if (start_s) begin
            state_s   = ST_SHIFT;
            sr_s      = start_data_s;
            bit_cnt_s = '0;
            div_cnt_s = '0;
        end else begin
            state_s = state_s;
        end

        if (load && (state_r != ST_IDLE) && !load_taken_s) begin
            pend_data_s  = data_in;
            pend_valid_s = 1'b1;
        end else begin
            pend_valid_s = pend_valid_s;
        end
    end

    // Pin values for the cycle being entered, so the outputs can be registered
    always_comb begin
        sclk_s = 1'b0;
        sdo_s  = 1'b0;
        pen_s  = 1'b1;
        busy_s = (state_s != ST_IDLE);
        if (state_s == ST_SHIFT) begin
            sclk_s = (div_cnt_s >= DIV_HALF);
            sdo_s  = sr_s[DATA_WIDTH-1];
            pen_s  = 1'b0;
        end else begin
            sclk_s = 1'b0;
            sdo_s  = 1'b0;
            pen_s  = 1'b1;
        end
    end

    // State, shift register, counters and pending buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            sr_r         <= '0;
            bit_cnt_r    <= '0;
            div_cnt_r    <= '0;
            pend_data_r  <= '0;
            pend_valid_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            sr_r         <= sr_s;
            bit_cnt_r    <= bit_cnt_s;
            div_cnt_r    <= div_cnt_s;
            pend_data_r  <= pend_data_s;
            pend_valid_r <= pend_valid_s;
        end
    end

    // Registered board-facing outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_r  <= 1'b0;
            sdo_r   <= 1'b0;
            pen_r   <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            clr_n_r <= 1'b0;
        end else begin
            sclk_r  <= sclk_s;
            sdo_r   <= sdo_s;
            pen_r   <= pen_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            clr_n_r <= 1'b1;
        end
    end

    assign sclk  = sclk_r;
    assign sdo   = sdo_r;
    assign pen   = pen_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign clr_n = clr_n_r;

endmodule

// File: tb/tb_serial_seg_shifter.sv
// Self-checking bench for serial_seg_shifter: frame-level reference model plus directed vectors.
// Builds with or without SEG_AUTO_REFRESH_EN; the refresh expectations follow the macro.
module tb_serial_seg_shifter;

    localparam int W  = 8;
    localparam int RP = 50;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load8 = 1'b0;
    logic         load3 = 1'b0;
    logic [W-1:0] data8 = 8'h00;
    logic [W-1:0] data3 = 8'h00;

    logic busy8, done8, sclk8, sdo8, pen8, clr_n8;
    logic busy3, done3, sclk3, sdo3, pen3, clr_n3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_seg_shifter #(.DATA_WIDTH(W), .DIV(1), .REFRESH_PERIOD(RP)) u8 (
        .clk(clk), .rst(rst), .data_in(data8), .load(load8),
        .busy(busy8), .done(done8), .sclk(sclk8), .sdo(sdo8), .pen(pen8), .clr_n(clr_n8)
    );

    serial_seg_shifter #(.DATA_WIDTH(W), .DIV(3), .REFRESH_PERIOD(RP)) u3 (
        .clk(clk), .rst(rst), .data_in(data3), .load(load3),
        .busy(busy3), .done(done3), .sclk(sclk3), .sdo(sdo3), .pen(pen3), .clr_n(clr_n3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is "k cycles since its first shift cycle"
    bit           m_rst[2];
    bit           m_active[2];
    int           m_k[2];
    logic [W-1:0] m_frame[2];
    logic [W-1:0] m_pend[2];
    bit           m_pv[2];
    logic [W-1:0] m_shadow[2];
    bit           m_shv[2];
    int           m_idle[2];
    bit           m_done[2];

    task automatic m_start(input int u, input logic [W-1:0] d);
        m_active[u] = 1'b1;
        m_k[u]      = 0;
        m_frame[u]  = d;
        m_shadow[u] = d;
        m_shv[u]    = 1'b1;
        m_idle[u]   = 0;
    endtask

    task automatic model_step(input int u, input bit r, input bit ld, input logic [W-1:0] d);
        int dv;
        bit fire;
        dv        = (u == 0) ? 1 : 3;
        m_rst[u]  = r;
        m_done[u] = 1'b0;
        if (r) begin
            m_active[u] = 1'b0;
            m_pv[u]     = 1'b0;
            m_shv[u]    = 1'b0;
            m_idle[u]   = 0;
        end else if (!m_active[u]) begin
            fire = 1'b0;
`ifdef SEG_AUTO_REFRESH_EN
            fire = m_shv[u] && (m_idle[u] == RP - 1);
`endif
            if (ld) m_start(u, d);
            else if (fire) m_start(u, m_shadow[u]);
            else m_idle[u]++;
        end else begin
            m_k[u]++;
            if (m_k[u] == 2 * dv * (W + 1)) begin
                m_done[u] = 1'b1;
                if (m_pv[u]) begin
                    m_start(u, m_pend[u]);
                    m_pv[u] = 1'b0;
                    if (ld) begin
                        m_pend[u] = d;
                        m_pv[u]   = 1'b1;
                    end
                end else if (ld) begin
                    m_start(u, d);
                end else begin
                    m_active[u] = 1'b0;
                    m_idle[u]   = 0;
                end
            end else if (ld) begin
                m_pend[u] = d;
                m_pv[u]   = 1'b1;
            end
        end
    endtask

    // Expected {clr_n, done, busy, pen, sdo, sclk}
    function automatic logic [5:0] model_out(input int u);
        int dv;
        int half;
        dv   = (u == 0) ? 1 : 3;
        half = 2 * dv;
        if (m_rst[u]) return 6'b000100;
        if (!m_active[u]) return {1'b1, m_done[u], 1'b0, 1'b1, 1'b0, 1'b0};
        if (m_k[u] < half * W)
            return {1'b1, m_done[u], 1'b1, 1'b0, m_frame[u][W - 1 - m_k[u] / half],
                    (m_k[u] % half) >= dv};
        return {1'b1, m_done[u], 1'b1, 1'b1, 1'b0, 1'b0};
    endfunction

    // Per-cycle comparison of both instances against the model
    initial begin
        bit           r, l8, l3;
        logic [W-1:0] d8, d3;
        forever begin
            @(posedge clk);
            r  = rst;
            l8 = load8;
            d8 = data8;
            l3 = load3;
            d3 = data3;
            #1;
            model_step(0, r, l8, d8);
            model_step(1, r, l3, d3);
            chk("u8_pins", {26'd0, clr_n8, done8, busy8, pen8, sdo8, sclk8}, {26'd0, model_out(0)});
            chk("u3_pins", {26'd0, clr_n3, done3, busy3, pen3, sdo3, sclk3}, {26'd0, model_out(1)});
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] got;
        logic [8:0]  sdo_v;
        logic [8:0]  sclk_v;
        bit          prev;
        int          rises;
        int          dones;
        int          act;

        // Reset and release
        repeat (3) tick();
        chk("rst_clr_n", {31'd0, clr_n8}, 32'd0);
        chk("rst_pen", {31'd0, pen8}, 32'd1);
        rst = 1'b0;
        tick();
        chk("rel_clr_n", {31'd0, clr_n8}, 32'd1);
        chk("rel_idle", {28'd0, sclk8, pen8, busy8, done8}, 32'b0100);

        // Single frame 8'hA5
        data8 = 8'hA5; load8 = 1'b1;
        tick();
        load8 = 1'b0;
        got = '0; prev = 1'b0;
        for (int j = 0; j < 19; j++) begin
            if (j != 0) tick();
            if (j == 0) chk("a5_first_sdo", {31'd0, sdo8}, 32'd1);
            if (sclk8 && !prev) got = {got[14:0], sdo8};
            prev = sclk8;
            if (j == 15) chk("a5_pen_low", {31'd0, pen8}, 32'd0);
            if (j == 16) chk("a5_pen_rise", {31'd0, pen8}, 32'd1);
            if (j == 17) chk("a5_no_done_yet", {31'd0, done8}, 32'd0);
            if (j == 18) chk("a5_done_busy", {30'd0, done8, busy8}, 32'b10);
        end
        chk("a5_bits", {16'd0, got}, 32'h00A5);

        // 8'h3C then two loads while busy: last write wins
        data8 = 8'h3C; load8 = 1'b1;
        tick();
        load8 = 1'b0;
        got = '0; prev = 1'b0; dones = 0;
        for (int j = 0; j < 45; j++) begin
            if (j != 0) tick();
            if (sclk8 && !prev) got = {got[14:0], sdo8};
            prev = sclk8;
            if (done8) dones++;
            if (j == 18) chk("b2b_busy", {31'd0, busy8}, 32'd1);
            if (j == 2) begin load8 = 1'b1; data8 = 8'h11; end
            if (j == 3) load8 = 1'b0;
            if (j == 6) begin load8 = 1'b1; data8 = 8'hF0; end
            if (j == 7) load8 = 1'b0;
        end
        chk("b2b_bits", {16'd0, got}, 32'h3CF0);
        chk("b2b_dones", dones, 32'd2);

        // Reset at the 4th sclk rise of 8'hFF, with a frame pending and a load during rst
        data8 = 8'hFF; load8 = 1'b1;
        tick();
        load8 = 1'b0;
        rises = 0; prev = 1'b0;
        for (int j = 0; j < 8; j++) begin
            if (j != 0) tick();
            if (sclk8 && !prev) rises++;
            prev = sclk8;
            if (j == 2) begin load8 = 1'b1; data8 = 8'h55; end
            if (j == 3) load8 = 1'b0;
        end
        chk("ff_rise4", rises, 32'd4);
        rst = 1'b1; load8 = 1'b1; data8 = 8'hC3;
        tick();
        rst = 1'b0; load8 = 1'b0;
        chk("abort_pins", {27'd0, sclk8, sdo8, pen8, busy8, done8}, 32'b00100);
        act = 0;
        for (int j = 0; j < 60; j++) begin
            tick();
            if (sclk8 || busy8 || done8) act++;
        end
        chk("no_activity_after_rst", act, 32'd0);

        // DIV=3 instance, 8'h80
        data3 = 8'h80; load3 = 1'b1;
        tick();
        load3 = 1'b0;
        sdo_v = '0; sclk_v = '0;
        for (int j = 0; j < 9; j++) begin
            if (j != 0) tick();
            sdo_v  = {sdo_v[7:0], sdo3};
            sclk_v = {sclk_v[7:0], sclk3};
        end
        chk("div3_sdo", {23'd0, sdo_v}, 32'b111111000);
        chk("div3_sclk", {23'd0, sclk_v}, 32'b000111000);

        // 8'h5A then idle: refresh behaviour depends on the build
        data8 = 8'h5A; load8 = 1'b1;
        tick();
        load8 = 1'b0;
        act = 0;
        for (int j = 0; j < 141; j++) begin
            if (j != 0) tick();
            if (j == 18) chk("5a_done", {31'd0, done8}, 32'd1);
`ifdef SEG_AUTO_REFRESH_EN
            if (j == 67)  chk("refresh1_not_yet", {31'd0, busy8}, 32'd0);
            if (j == 68)  chk("refresh1_start", {30'd0, busy8, sdo8}, 32'b10);
            if (j == 86)  chk("refresh1_done", {31'd0, done8}, 32'd1);
            if (j == 135) chk("refresh2_not_yet", {31'd0, busy8}, 32'd0);
            if (j == 136) chk("refresh2_start", {31'd0, busy8}, 32'd1);
`else
            if (j > 18 && (busy8 || sclk8)) act++;
`endif
        end
`ifndef SEG_AUTO_REFRESH_EN
        chk("no_refresh", act, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
